// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT-line receive path.
// Contents:
//   sd_dat_rx_state_e : receive FSM state encoding
//   Crc16Poly, CrcBits: CRC16-CCITT parameters
//   crc16_step        : one serial CRC16 update (MSB-first, no reflection)
package sd_dat_pkg;

  localparam int unsigned CrcBits   = 16;
  localparam logic [CrcBits-1:0] Crc16Poly = 16'h1021;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StData,
    StCrc,
    StEndBit,
    StDone
  } sd_dat_rx_state_e;

  // Shift one data bit into the CRC; feedback is the incoming bit XOR the CRC MSB.
  function automatic logic [CrcBits-1:0] crc16_step(input logic [CrcBits-1:0] crc,
                                                    input logic               data_bit);
    logic fb;
    fb = data_bit ^ crc[CrcBits-1];
    return {crc[CrcBits-2:0], 1'b0} ^ (fb ? Crc16Poly : '0);
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Serial CRC16-CCITT generator, one bit per enabled clock.
// Ports:
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset, clears the CRC
//   clear_i : synchronous clear to 0x0000 (wins over en_i)
//   en_i    : shift bit_i into the CRC this clock
//   bit_i   : serial data bit
//   crc_o   : current CRC remainder
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic [CrcBits-1:0] crc_o
);

  logic [CrcBits-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_rx.sv
// SD DAT-line receive deserializer.
// Hunts for the start bit on DAT0, shifts in one block on 1 or 4 lanes, packs bytes into
// 32-bit little-endian words, then checks the per-lane CRC16 and the end bit.
// Ports:
//   clk_i, rst_i      : system clock, asynchronous active-high reset
//   sd_clk_en_i       : one-clk strobe marking an SD-clock rising edge (DAT sample point)
//   dat_i[3:0]        : SD DAT lanes, lane 0 is LSB
//   start_i           : receive request, accepted only when idle
//   abort_i           : synchronous abort back to idle
//   block_size_i      : bytes per block, latched on start
//   bus_width_is_4_i  : 1 = 4-bit bus, 0 = DAT0 only, latched on start
//   data_valid_o      : one-clk strobe, data_o holds a packed word
//   data_o            : packed word, first bus byte in [7:0]
//   done_o            : one-clk strobe at end of block
//   crc_err_o         : CRC mismatch on any active lane (qualified by done_o)
//   end_bit_err_o     : end bit low on any active lane (qualified by done_o)
module sd_dat_rx
  import sd_dat_pkg::*;
#(
  parameter int unsigned MaxBlockBitSize = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sd_clk_en_i,
  input  logic [3:0]                 dat_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic                       bus_width_is_4_i,
  output logic                       data_valid_o,
  output logic [31:0]                data_o,
  output logic                       done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o
);

  localparam logic [MaxBlockBitSize-1:0] ByteOne = MaxBlockBitSize'(1);

  sd_dat_rx_state_e state_q, state_d;

  logic [MaxBlockBitSize-1:0] size_q, size_d;
  logic [MaxBlockBitSize-1:0] byte_cnt_q, byte_cnt_d;
  logic                       wide_q, wide_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [3:0]                 crc_cnt_q, crc_cnt_d;
  logic [7:0]                 byte_q, byte_d;
  logic [31:0]                word_q, word_d;
  logic [31:0]                data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       crc_err_q, crc_err_d;
  logic                       end_err_q, end_err_d;

  logic               crc_clear;
  logic               crc_en;
  logic [3:0]         lane_mask;
  logic [CrcBits-1:0] crc_val [4];
  logic [3:0]         crc_exp;
  logic               crc_mis;
  logic [7:0]         byte_next;
  logic               byte_done;
  logic               last_byte;
  logic [31:0]        word_ins;

  // Lanes 3:1 are inert in 1-bit mode: no CRC update, no CRC or end-bit check.
  assign lane_mask = wide_q ? 4'hF : 4'h1;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    sd_crc16_serial u_crc (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (crc_clear),
      .en_i    (crc_en & lane_mask[l]),
      .bit_i   (dat_i[l]),
      .crc_o   (crc_val[l])
    );
  end

  // Received CRC arrives MSB first, so sample n is checked against bit 15-n (== ~n).
  always_comb begin
    crc_exp = '0;
    for (int l = 0; l < 4; l++) begin
      crc_exp[l] = crc_val[l][~crc_cnt_q];
    end
  end
  assign crc_mis = |((dat_i ^ crc_exp) & lane_mask);

  // Byte assembly: one bit of DAT0 or one nibble per sample, MSB first.
  assign byte_next = wide_q ? {byte_q[3:0], dat_i} : {byte_q[6:0], dat_i[0]};
  assign byte_done = wide_q ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd7);
  assign last_byte = (byte_cnt_q == (size_q - ByteOne));

  // Byte 0 of each word starts from zero so a trailing partial word has clean upper bytes.
  always_comb begin
    word_ins = (byte_cnt_q[1:0] == 2'd0) ? 32'h0 : word_q;
    word_ins[{byte_cnt_q[1:0], 3'b000} +: 8] = byte_next;
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    wide_d     = wide_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    byte_d     = byte_q;
    word_d     = word_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          size_d     = block_size_i;
          wide_d     = bus_width_is_4_i;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          crc_cnt_d  = '0;
          byte_d     = '0;
          word_d     = '0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
          crc_clear  = 1'b1;
          state_d    = StWaitStart;
        end
      end

      StWaitStart: begin
        if (sd_clk_en_i && !dat_i[0]) begin
          state_d = (size_q == '0) ? StCrc : StData;
        end
      end

      StData: begin
        if (sd_clk_en_i) begin
          crc_en = 1'b1;
          byte_d = byte_next;
          if (byte_done) begin
            bit_cnt_d = '0;
            word_d    = word_ins;
            if (byte_cnt_q[1:0] == 2'd3 || last_byte) begin
              valid_d = 1'b1;
              data_d  = word_ins;
            end
            if (last_byte) begin
              state_d = StCrc;
            end else begin
              byte_cnt_d = byte_cnt_q + ByteOne;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      StCrc: begin
        if (sd_clk_en_i) begin
          if (crc_mis) begin
            crc_err_d = 1'b1;
          end
          crc_cnt_d = crc_cnt_q + 4'd1;
          if (crc_cnt_q == 4'd15) begin
            state_d = StEndBit;
          end
        end
      end

      StEndBit: begin
        if (sd_clk_en_i) begin
          if (|(~dat_i & lane_mask)) begin
            end_err_d = 1'b1;
          end
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything in flight; data_o keeps the last delivered word.
    if (abort_i) begin
      state_d = StIdle;
      valid_d = 1'b0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      size_q     <= '0;
      wide_q     <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      byte_q     <= '0;
      word_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      wide_q     <= wide_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      byte_q     <= byte_d;
      word_q     <= word_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
    end
  end

  assign data_valid_o  = valid_q;
  assign data_o        = data_q;
  assign done_o        = (state_q == StDone);
  assign crc_err_o     = done_o & crc_err_q;
  assign end_bit_err_o = done_o & end_err_q;

endmodule

// File: tb/tb_sd_dat_rx.sv
// Directed bench for sd_dat_rx: builds per-lane bit streams with a local CRC16 model and
// checks delivered words and done flags against hand-derived values.
module tb_sd_dat_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sd_clk_en_i = 1'b0;
  logic [3:0]  dat_i = 4'hF;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [9:0]  block_size_i = '0;
  logic        bus_width_is_4_i = 1'b0;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic        done_o;
  logic        crc_err_o;
  logic        end_bit_err_o;

  sd_dat_rx #(.MaxBlockBitSize(10)) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .sd_clk_en_i      (sd_clk_en_i),
    .dat_i            (dat_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .block_size_i     (block_size_i),
    .bus_width_is_4_i (bus_width_is_4_i),
    .data_valid_o     (data_valid_o),
    .data_o           (data_o),
    .done_o           (done_o),
    .crc_err_o        (crc_err_o),
    .end_bit_err_o    (end_bit_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int div      = 1;

  logic [7:0]  blk   [0:511];
  logic [3:0]  ticks [0:4199];
  int          ntick;

  // Output monitor, sampled on the falling edge.
  logic [31:0] words [0:1023];
  int          nwords = 0;
  int          ndone  = 0;
  logic        last_crc_err = 1'b0;
  logic        last_end_err = 1'b0;

  always @(negedge clk_i) begin
    if (data_valid_o) begin
      words[nwords % 1024] <= data_o;
      nwords <= nwords + 1;
    end
    if (done_o) begin
      ndone        <= ndone + 1;
      last_crc_err <= crc_err_o;
      last_end_err <= end_bit_err_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // One SD sample: hold dat_i and strobe sd_clk_en_i for one clk, then div-1 quiet clks.
  task automatic tick(input logic [3:0] d);
    dat_i       = d;
    sd_clk_en_i = 1'b1;
    @(posedge clk_i); #1;
    sd_clk_en_i = 1'b0;
    for (int i = 1; i < div; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  // Stream: idle, start bit, data, 16 CRC bits, end bit. Unused lanes carry junk in 1-bit mode.
  task automatic build(input int size, input bit wide, input int flip_lane, input int zero_lane);
    logic [15:0] crc [4];
    logic [3:0]  v;
    int          n;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
    n = 0;
    ticks[n] = 4'hF; n++;
    ticks[n] = wide ? 4'b1110 : 4'b1010; n++;
    for (int k = 0; k < size; k++) begin
      if (wide) begin
        for (int h = 0; h < 2; h++) begin
          v = (h == 0) ? blk[k][7:4] : blk[k][3:0];
          for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], v[l]);
          ticks[n] = v; n++;
        end
      end else begin
        for (int b = 7; b >= 0; b--) begin
          v = {3'(n), blk[k][b]};
          crc[0] = crc_step(crc[0], blk[k][b]);
          ticks[n] = v; n++;
        end
      end
    end
    for (int j = 15; j >= 0; j--) begin
      for (int l = 0; l < 4; l++) v[l] = crc[l][j] ^ ((l == flip_lane) && (j == 5));
      if (!wide) v[3:1] = 3'(j);
      ticks[n] = v; n++;
    end
    v = 4'hF;
    if (zero_lane >= 0) v[zero_lane] = 1'b0;
    if (!wide) v[3:1] = 3'b000;
    ticks[n] = v; n++;
    ntick = n;
  endtask

  task automatic request(input int size, input bit wide);
    block_size_i     = 10'(size);
    bus_width_is_4_i = wide;
    start_i          = 1'b1;
    @(posedge clk_i); #1;
    start_i          = 1'b0;
  endtask

  task automatic play(input int abort_at, input int rst_at);
    for (int i = 0; i < ntick; i++) begin
      if (i == abort_at) begin
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
      end
      if (i == rst_at) begin
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
      end
      tick(ticks[i]);
    end
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int wb, db;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", {31'b0, data_valid_o}, 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_done", {31'b0, done_o}, 32'h0);
    check("rst_flags", {30'b0, crc_err_o, end_bit_err_o}, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 1-bit, 512 bytes of k&0xFF.
    div = 2;
    for (int k = 0; k < 512; k++) blk[k] = 8'(k);
    build(512, 1'b0, -1, -1);
    wb = nwords; db = ndone;
    request(512, 1'b0);
    play(-1, -1);
    check("b1_nwords", 32'(nwords - wb), 32'd128);
    for (int i = 0; i < 128; i++) begin
      check($sformatf("b1_word%0d", i), words[wb + i],
            {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
    end
    check("b1_done", 32'(ndone - db), 32'd1);
    check("b1_flags", {30'b0, last_crc_err, last_end_err}, 32'h0);

    // 4-bit, 8 bytes 0x01..0x08.
    div = 1;
    for (int k = 0; k < 8; k++) blk[k] = 8'(k + 1);
    build(8, 1'b1, -1, -1);
    wb = nwords; db = ndone;
    request(8, 1'b1);
    play(-1, -1);
    check("b4_nwords", 32'(nwords - wb), 32'd2);
    check("b4_word0", words[wb], 32'h04030201);
    check("b4_word1", words[wb + 1], 32'h08070605);
    check("b4_done", 32'(ndone - db), 32'd1);
    check("b4_flags", {30'b0, last_crc_err, last_end_err}, 32'h0);

    // 4-bit, 6 bytes: trailing partial word.
    build(6, 1'b1, -1, -1);
    wb = nwords; db = ndone;
    request(6, 1'b1);
    play(-1, -1);
    check("p6_nwords", 32'(nwords - wb), 32'd2);
    check("p6_word0", words[wb], 32'h04030201);
    check("p6_word1", words[wb + 1], 32'h00000605);
    check("p6_done", 32'(ndone - db), 32'd1);
    check("p6_hold", data_o, 32'h00000605);

    // CRC bit 5 flipped on lane 2.
    build(8, 1'b1, 2, -1);
    wb = nwords; db = ndone;
    request(8, 1'b1);
    play(-1, -1);
    check("ce_nwords", 32'(nwords - wb), 32'd2);
    check("ce_word1", words[wb + 1], 32'h08070605);
    check("ce_done", 32'(ndone - db), 32'd1);
    check("ce_flags", {30'b0, last_crc_err, last_end_err}, 32'h2);

    // End bit low on lane 3.
    build(8, 1'b1, -1, 3);
    wb = nwords; db = ndone;
    request(8, 1'b1);
    play(-1, -1);
    check("ee_nwords", 32'(nwords - wb), 32'd2);
    check("ee_done", 32'(ndone - db), 32'd1);
    check("ee_flags", {30'b0, last_crc_err, last_end_err}, 32'h1);

    // Abort after 3 bytes.
    build(8, 1'b1, -1, -1);
    wb = nwords; db = ndone;
    request(8, 1'b1);
    play(8, -1);
    check("ab_nwords", 32'(nwords - wb), 32'd0);
    check("ab_done", 32'(ndone - db), 32'd0);

    // Reset after 2 bytes.
    wb = nwords; db = ndone;
    request(8, 1'b1);
    play(-1, 6);
    check("rs_nwords", 32'(nwords - wb), 32'd0);
    check("rs_done", 32'(ndone - db), 32'd0);
    check("rs_data", data_o, 32'h0);

    // Clean 4-byte block after abort/reset.
    build(4, 1'b1, -1, -1);
    wb = nwords; db = ndone;
    request(4, 1'b1);
    play(-1, -1);
    check("rc_nwords", 32'(nwords - wb), 32'd1);
    check("rc_word0", words[wb], 32'h04030201);
    check("rc_done", 32'(ndone - db), 32'd1);
    check("rc_flags", {30'b0, last_crc_err, last_end_err}, 32'h0);

    // Slow SD clock, start held 3 clks, DAT0 low on a strobe before WAIT_START entry.
    div = 4;
    blk[0] = 8'hA1; blk[1] = 8'hB2; blk[2] = 8'hC3; blk[3] = 8'hD4;
    build(4, 1'b1, -1, -1);
    wb = nwords; db = ndone;
    tick(4'h0);
    tick(4'h0);
    block_size_i     = 10'd4;
    bus_width_is_4_i = 1'b1;
    start_i          = 1'b1;
    sd_clk_en_i      = 1'b1;
    dat_i            = 4'h0;
    @(posedge clk_i); #1;
    sd_clk_en_i      = 1'b0;
    dat_i            = 4'hF;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i          = 1'b0;
    @(posedge clk_i); #1;
    play(-1, -1);
    check("sl_nwords", 32'(nwords - wb), 32'd1);
    check("sl_word0", words[wb], 32'hD4C3B2A1);
    check("sl_done", 32'(ndone - db), 32'd1);
    check("sl_flags", {30'b0, last_crc_err, last_end_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
